// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-source merging multiplexer: word/count widths,
// source identifiers and the output-slot state encoding.
package mux2_arb_pkg;

    localparam int   WORD_WIDTH = 16;
    localparam int   CNT_WIDTH  = 16;
    localparam logic SRC_A      = 1'b0;
    localparam logic SRC_B      = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/mux2_arb_if.sv
// Handshake bundle for mux2_arb: two valid/ready input channels, the merged
// output channel and the per-source acceptance counters.
interface mux2_arb_if
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) ();

    logic                 a_valid;
    logic [WIDTH-1:0]     a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [WIDTH-1:0]     b_data;
    logic                 b_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ready;
    logic                 out_src;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, cnt_a, cnt_b
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, cnt_a, cnt_b
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the source
// that did not win last time.
module rr_arb2
    import mux2_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_src,
    output logic gnt_a,
    output logic gnt_b
);

    assign gnt_a = req_a && (!req_b || (last_src == SRC_B));
    assign gnt_b = req_b && (!req_a || (last_src == SRC_A));

endmodule

// File: rtl/mux2_arb.sv
// 2:1 merging multiplexer with a one-entry registered output slot, round-robin
// input selection and per-source word counters.
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    mux2_arb_if.slave bus
);

    slot_state_t          state_q, state_d;
    logic                 last_src_q;
    logic                 src_q;
    logic [WIDTH-1:0]     data_q;
    logic [CNT_WIDTH-1:0] cnt_a_q, cnt_b_q;
    logic                 gnt_a, gnt_b;
    logic                 slot_free;
    logic                 acc_a, acc_b;

    // The slot can take a word when empty, or when its current word leaves this cycle.
    assign slot_free = (state_q == ST_EMPTY) || bus.out_ready;

    rr_arb2 u_arb (
        .req_a    (bus.a_valid),
        .req_b    (bus.b_valid),
        .last_src (last_src_q),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b)
    );

    assign bus.a_ready = !rst && slot_free && gnt_a;
    assign bus.b_ready = !rst && slot_free && gnt_b;
    assign acc_a       = bus.a_valid && bus.a_ready;
    assign acc_b       = bus.b_valid && bus.b_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (acc_a || acc_b) state_d = ST_FULL;
            ST_FULL: begin
                if (acc_a || acc_b)     state_d = ST_FULL;
                else if (bus.out_ready) state_d = ST_EMPTY;
            end
            default:                    state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            src_q      <= SRC_A;
            last_src_q <= SRC_B;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            state_q <= state_d;
            if (acc_a) begin
                data_q     <= bus.a_data;
                src_q      <= SRC_A;
                last_src_q <= SRC_A;
                cnt_a_q    <= cnt_a_q + 1'b1;
            end else if (acc_b) begin
                data_q     <= bus.b_data;
                src_q      <= SRC_B;
                last_src_q <= SRC_B;
                cnt_b_q    <= cnt_b_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width (Hack word).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports a_valid input 1, a_data input WIDTH, a_ready output 1, forming source A's valid/ready input channel.
REQ-005 The block SHALL have ports b_valid input 1, b_data input WIDTH, b_ready output 1, forming source B's valid/ready input channel.
REQ-006 The block SHALL have ports out_valid output 1, out_data output WIDTH, out_ready input 1, forming the merged output channel.
REQ-007 The block SHALL have port out_src  output  1  origin of the held word (0 = A, 1 = B).
REQ-008 The block SHALL have ports cnt_a and cnt_b  output  16  count of words accepted from A and from B.

Function
REQ-009 The block SHALL be a 2:1 merging multiplexer, the inverse of the demultiplexer: two input streams feed one output stream through a one-entry registered output stage.
REQ-010 A transfer on any channel SHALL occur exactly in a cycle with valid=1 and ready=1 at the rising clk edge.
REQ-011 The output stage SHALL be able to accept a word (slot_free) when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (pass-through at full throughput).
REQ-012 Grant SHALL be round-robin via register last_src: only A valid -> A; only B valid -> B; both valid -> the source not equal to last_src.
REQ-013 a_ready SHALL be 1 only when slot_free=1 and A is granted; b_ready likewise for B; a_ready and b_ready SHALL never both be 1.
REQ-014 On an accepted input, out_data, out_src and last_src SHALL load the winning data and source id, and out_valid SHALL be 1 the next cycle; latency in to out SHALL be 1 cycle.
REQ-015 When out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable, and both input readys SHALL be 0.
REQ-016 When out_valid=1, out_ready=1 and no input is accepted, out_valid SHALL go to 0 the next cycle.
REQ-017 out_valid, once asserted, SHALL not drop until accepted.
REQ-018 cnt_a and cnt_b SHALL each increment by 1 per accepted word from their source and wrap from 16'hFFFF to 16'h0000 without saturation.
REQ-019 The output stage SHALL behave as a two-state machine: EMPTY moves to FULL on accept; FULL stays FULL on simultaneous drain and accept; FULL moves to EMPTY on drain without accept; FULL stays FULL on stall.
REQ-020 a_ready and b_ready MAY depend combinationally on a_valid, b_valid and out_ready; out_valid SHALL be purely registered.

Reset
REQ-021 While rst=1, the block SHALL immediately force out_valid=0, out_data=0, out_src=0, cnt_a=0, cnt_b=0 and last_src=1, so A wins the first tie.
REQ-022 While rst=1, a_ready and b_ready SHALL be 0.
REQ-023 rst asserted mid-transfer SHALL discard the held word, and no partial count SHALL survive.
REQ-024 Operation SHALL resume on the first rising clk edge after rst deasserts.

Structure
REQ-025 Shared include hack_defs.vh SHALL hold WORD_WIDTH=16, SRC_A=1'b0, SRC_B=1'b1 and CNT_WIDTH=16.
REQ-026 Round-robin grant logic SHALL be a separate sub-module rr_arb2 (inputs req_a, req_b, last_src; outputs gnt_a, gnt_b).
REQ-027 The output register, counters and last_src SHALL be in mux2_arb.

Verification
REQ-028 The bench SHALL cover: reset with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, cnt_a=cnt_b=0.
REQ-029 The bench SHALL cover: A alone sends 16'h1234 with out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_src=0, cnt_a=1.
REQ-030 The bench SHALL cover: both valid continuously (A=16'hAAAA, B=16'hBBBB), out_ready=1 -> outputs alternate AAAA, BBBB, AAAA... at one word per cycle, starting with A.
REQ-031 The bench SHALL cover: out_ready=0 for 3 cycles while holding 16'h00FF -> out_data stays 16'h00FF, a_ready=b_ready=0 throughout.
REQ-032 The bench SHALL cover: preload cnt_b to 16'hFFFF via 65535 B transfers, then one more -> cnt_b=16'h0000, cnt_a unchanged.
REQ-033 The bench SHALL cover: rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 immediately, and after release the first tie goes to A.
